// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one backing-memory port between the I-side (read-only)
// and D-side (read/write) request channels. One transaction is outstanding at a
// time; D-side wins ties unless it has already taken MAX_D_STREAK consecutive
// grants while the I-side was waiting. A WAIT-state timer aborts transactions
// the memory never answers and returns an error to the owner.
module mem_port_arbiter #(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic              clk,
   input  logic              rst,
   // I-side channel
   input  logic              i_req_valid_i,
   input  logic [ADDR_W-1:0] i_addr_i,
   output logic              i_ready_o,
   output logic              i_rvalid_o,
   output logic [DATA_W-1:0] i_rdata_o,
   output logic              i_err_o,
   // D-side channel
   input  logic              d_req_valid_i,
   input  logic              d_wen_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   input  logic [1:0]        d_wlen_i,
   output logic              d_ready_o,
   output logic              d_rvalid_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_err_o,
   // Memory port
   output logic              mem_req_valid_o,
   input  logic              mem_ready_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_wen_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [1:0]        mem_wlen_o,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o
);

   // Counter widths sized to hold the parameter value itself.
   localparam int SW = (MAX_D_STREAK < 2) ? 1 : $clog2(MAX_D_STREAK + 1);
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
   localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   logic [1:0]        state;
   logic [SW-1:0]     streak;
   logic [TW-1:0]     timer;
   logic              owner;
   logic [ADDR_W-1:0] addr;
   logic              wen;
   logic [DATA_W-1:0] wdata;
   logic [1:0]        wlen;
   logic              i_rvalid;
   logic [DATA_W-1:0] i_rdata;
   logic              i_err;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              d_err;
   logic              d_win;
   logic              i_win;
   logic              timed_out;

   // Pick the requester that would win if the arbiter were idle this cycle.
   always_comb begin
      d_win = 1'b0;
      i_win = 1'b0;
      if (d_req_valid_i && !(i_req_valid_i && (streak == STREAK_MAX))) begin
         d_win = 1'b1;
      end else if (i_req_valid_i) begin
         i_win = 1'b1;
      end else begin
         d_win = 1'b0;
         i_win = 1'b0;
      end
   end

   // Timer abort condition; a zero TIMEOUT disables it entirely.
   always_comb begin
      timed_out = 1'b0;
      if ((TIMEOUT != 0) && (timer == TIMER_MAX)) begin
         timed_out = 1'b1;
      end else begin
         timed_out = 1'b0;
      end
   end

   // Ready is combinational so a request is accepted in the same IDLE cycle.
   assign i_ready_o       = (state == ST_IDLE) && i_win;
   assign d_ready_o       = (state == ST_IDLE) && d_win;
   assign mem_req_valid_o = (state == ST_REQ);
   assign busy_o          = (state != ST_IDLE);
   assign mem_addr_o      = addr;
   assign mem_wen_o       = wen;
   assign mem_wdata_o     = wdata;
   assign mem_wlen_o      = wlen;
   assign i_rvalid_o      = i_rvalid;
   assign i_rdata_o       = i_rdata;
   assign i_err_o         = i_err;
   assign d_rvalid_o      = d_rvalid;
   assign d_rdata_o       = d_rdata;
   assign d_err_o         = d_err;

   // Transaction FSM, streak counter, WAIT timer and registered responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         streak   <= '0;
         timer    <= '0;
         owner    <= OWN_I;
         addr     <= '0;
         wen      <= 1'b0;
         wdata    <= '0;
         wlen     <= 2'b00;
         i_rvalid <= 1'b0;
         i_rdata  <= '0;
         i_err    <= 1'b0;
         d_rvalid <= 1'b0;
         d_rdata  <= '0;
         d_err    <= 1'b0;
      end else begin
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (d_win) begin
                  owner <= OWN_D;
                  addr  <= d_addr_i;
                  wen   <= d_wen_i;
                  wdata <= d_wdata_i;
                  wlen  <= d_wlen_i;
                  state <= ST_REQ;
                  // Only D grants taken while I waits count toward the streak.
                  if (i_req_valid_i) begin
                     streak <= (streak == STREAK_MAX) ? streak : streak + SW'(1);
                  end else begin
                     streak <= '0;
                  end
               end else if (i_win) begin
                  owner  <= OWN_I;
                  addr   <= i_addr_i;
                  wen    <= 1'b0;
                  wdata  <= '0;
                  wlen   <= 2'b00;
                  state  <= ST_REQ;
                  streak <= '0;
               end
            end
            ST_REQ: begin
               if (mem_ready_i) begin
                  timer <= '0;
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // A response arriving on the timeout cycle still counts as success.
               if (mem_rvalid_i) begin
                  state <= ST_RESP;
                  if (owner == OWN_D) begin
                     d_rvalid <= 1'b1;
                     d_rdata  <= wen ? '0 : mem_rdata_i;
                     d_err    <= 1'b0;
                  end else begin
                     i_rvalid <= 1'b1;
                     i_rdata  <= mem_rdata_i;
                     i_err    <= 1'b0;
                  end
               end else if (timed_out) begin
                  state <= ST_RESP;
                  if (owner == OWN_D) begin
                     d_rvalid <= 1'b1;
                     d_rdata  <= '0;
                     d_err    <= 1'b1;
                  end else begin
                     i_rvalid <= 1'b1;
                     i_rdata  <= '0;
                     i_err    <= 1'b1;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter. The stimulus process
// predicts each grant from the arbitration rules, records the request it
// expects on the memory port, and plays a memory that answers after a chosen
// delay (or never). A separate monitor pops expected responses whenever the
// DUT pulses an rvalid.
module tb_mem_port_arbiter;
   localparam int AW   = 64;
   localparam int DW   = 64;
   localparam int MAXS = 4;
   localparam int TO   = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req_valid, i_ready, i_rvalid, i_err;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          d_req_valid, d_wen, d_ready, d_rvalid, d_err;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic [1:0]    d_wlen;
   logic          mem_req_valid, mem_ready, mem_wen, mem_rvalid, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [1:0]    mem_wlen;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid_i(i_req_valid), .i_addr_i(i_addr), .i_ready_o(i_ready),
      .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata), .i_err_o(i_err),
      .d_req_valid_i(d_req_valid), .d_wen_i(d_wen), .d_addr_i(d_addr),
      .d_wdata_i(d_wdata), .d_wlen_i(d_wlen), .d_ready_o(d_ready),
      .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata), .d_err_o(d_err),
      .mem_req_valid_o(mem_req_valid), .mem_ready_i(mem_ready),
      .mem_addr_o(mem_addr), .mem_wen_o(mem_wen), .mem_wdata_o(mem_wdata),
      .mem_wlen_o(mem_wlen), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit            side;   // 1 = D, 0 = I
      logic [AW-1:0] addr;
      bit            wen;
      logic [DW-1:0] wdata;
      logic [1:0]    wlen;
      int            gcyc;
   } fld_t;

   typedef struct {
      bit            side;
      logic [DW-1:0] rdata;
      bit            err;
      int            ecyc;
   } rsp_t;

   fld_t fq[$];
   rsp_t sb[$];

   int n_cmp = 0;
   int n_fail = 0;

   // requester / memory model state
   bit            i_pend, d_pend, dwen, cur_seen, log_on, data_fix;
   logic [AW-1:0] ia, da;
   logic [DW-1:0] dwd, rsp_data, fix_data;
   logic [1:0]    dwl;
   int            i_rate, d_rate, rdy_rate, k_force, rsp_cnt, m_streak;
   string         glog;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void chks(input string name, input string act, input string exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %s expected %s", name, act, exp);
      end
   endfunction

   task automatic drive_ports();
      i_req_valid = i_pend;
      i_addr      = ia;
      d_req_valid = d_pend;
      d_wen       = dwen;
      d_addr      = da;
      d_wdata     = dwd;
      d_wlen      = dwl;
   endtask

   // Sample at negedge: check grant, memory request fields, launch responses.
   task automatic decide();
      bit   ihs, dhs, exp_side;
      int   k;
      fld_t f;
      rsp_t r;
      chk("ready_exclusive", 64'(i_ready & d_ready), 64'd0);
      if (mem_req_valid) begin
         if (fq.size() == 0) begin
            chk("spurious_mem_req", 64'(mem_req_valid), 64'd0);
         end else begin
            f = fq[0];
            chk("mem_addr", mem_addr, f.addr);
            chk("mem_wen", 64'(mem_wen), 64'(f.wen));
            chk("mem_wlen", 64'(mem_wlen), 64'(f.wlen));
            if (f.side) chk("mem_wdata", mem_wdata, f.wdata);
            if (!cur_seen) begin
               chk("req_latency", 64'(cyc), 64'(f.gcyc + 1));
               cur_seen = 1'b1;
            end
            if (mem_ready) begin
               k = (k_force >= 0) ? k_force : int'($urandom_range(10));
               rsp_data = data_fix ? fix_data : {$urandom, $urandom};
               r.side  = f.side;
               r.err   = (k > TO);
               r.rdata = ((k > TO) || f.wen) ? 64'd0 : rsp_data;
               r.ecyc  = cyc + ((k > TO) ? TO : k) + 2;
               sb.push_back(r);
               rsp_cnt = (k > TO) ? -1 : k;
               void'(fq.pop_front());
               cur_seen = 1'b0;
            end
         end
      end
      ihs = i_ready && i_req_valid;
      dhs = d_ready && d_req_valid;
      if (ihs || dhs) begin
         exp_side = d_req_valid && !(i_req_valid && (m_streak == MAXS));
         chk("grant_side", 64'(dhs), 64'(exp_side));
         f.side  = dhs;
         f.addr  = dhs ? da : ia;
         f.wen   = dhs ? dwen : 1'b0;
         f.wdata = dhs ? dwd : 64'd0;
         f.wlen  = dhs ? dwl : 2'd0;
         f.gcyc  = cyc;
         fq.push_back(f);
         if (dhs) m_streak = i_req_valid ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
         else     m_streak = 0;
         if (log_on) glog = {glog, dhs ? "D" : "I"};
         if (dhs) d_pend = 1'b0;
         else     i_pend = 1'b0;
      end
   endtask

   // Drive after posedge: new requests, memory ready and responses.
   task automatic apply();
      if (!i_pend && ($urandom_range(99) < i_rate)) begin
         i_pend = 1'b1;
         ia = {$urandom, $urandom};
      end
      if (!d_pend && ($urandom_range(99) < d_rate)) begin
         d_pend = 1'b1;
         da   = {$urandom, $urandom};
         dwd  = {$urandom, $urandom};
         dwen = 1'($urandom_range(1));
         dwl  = 2'($urandom_range(3));
      end
      mem_ready = ($urandom_range(99) < rdy_rate);
      if (rsp_cnt == 0) begin
         mem_rvalid = 1'b1;
         mem_rdata  = rsp_data;
         rsp_cnt    = -1;
      end else begin
         mem_rvalid = 1'b0;
         mem_rdata  = {$urandom, $urandom};
         if (rsp_cnt > 0) rsp_cnt--;
      end
      drive_ports();
   endtask

   task automatic step();
      @(negedge clk);
      decide();
      @(posedge clk);
      #1;
      apply();
   endtask

   task automatic clear_model();
      fq.delete();
      sb.delete();
      cur_seen = 1'b0;
      m_streak = 0;
      rsp_cnt  = -1;
   endtask

   task automatic run_until_grants(input int n, input int budget);
      int b = 0;
      while ((glog.len() < n) && (b < budget)) begin
         step();
         b++;
      end
      chk("grant_budget", 64'(glog.len() >= n), 64'd1);
   endtask

   task automatic drain(input int budget);
      int b = 0;
      i_rate = 0; d_rate = 0; rdy_rate = 100;
      while (((sb.size() != 0) || (fq.size() != 0) || i_pend || d_pend) && (b < budget)) begin
         step();
         b++;
      end
      step();
      chk("drain_sb_empty", 64'(sb.size()), 64'd0);
      chk("drain_fq_empty", 64'(fq.size()), 64'd0);
   endtask

   // Monitor: pop the scoreboard whenever either side reports a response.
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         chk("rvalid_exclusive", 64'(i_rvalid & d_rvalid), 64'd0);
         if (i_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
               chk("unexpected_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
            end else begin
               e = sb.pop_front();
               chk("rsp_side", 64'(d_rvalid), 64'(e.side));
               chk("rsp_rdata", d_rvalid ? d_rdata : i_rdata, e.rdata);
               chk("rsp_err", 64'(d_rvalid ? d_err : i_err), 64'(e.err));
               chk("rsp_cycle", 64'(cyc), 64'(e.ecyc));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      i_pend = 0; d_pend = 0; dwen = 0; ia = '0; da = '0; dwd = '0; dwl = '0;
      i_rate = 0; d_rate = 0; rdy_rate = 100; k_force = 0;
      log_on = 0; data_fix = 0; fix_data = '0; glog = "";
      mem_ready = 0; mem_rvalid = 0; mem_rdata = '0; rsp_data = '0;
      clear_model();
      drive_ports();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mem_req", 64'(mem_req_valid), 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_mem_wen", 64'({mem_wen, mem_wlen}), 64'd0);
      chk("rst_rvalid", 64'({i_rvalid, d_rvalid, i_err, d_err}), 64'd0);
      chk("rst_rdata", i_rdata | d_rdata, 64'd0);
      chk("rst_ready", 64'({i_ready, d_ready}), 64'd0);
      @(posedge clk);
      #1;

      // I-only read, immediate memory: rvalid three cycles after accept.
      data_fix = 1; fix_data = 64'h13;
      i_pend = 1; ia = 64'h8000_0000; drive_ports();
      repeat (6) step();
      data_fix = 0;
      chk("t1_done", 64'(sb.size() + fq.size()), 64'd0);

      // D write: ack returns rdata 0, err 0.
      d_pend = 1; dwen = 1; da = 64'h100; dwd = 64'h1234; dwl = 2'd2; drive_ports();
      repeat (6) step();
      chk("t2_done", 64'(sb.size() + fq.size()), 64'd0);

      // Both sides held continuously: D,D,D,D,I repeating.
      glog = ""; log_on = 1; i_rate = 100; d_rate = 100;
      run_until_grants(10, 200);
      log_on = 0;
      chks("grant_order", glog, "DDDDIDDDDI");
      drain(200);

      // Memory never answers: error after TIMEOUT, then a normal request.
      k_force = 99;
      i_pend = 1; ia = 64'hdead_0000; drive_ports();
      repeat (14) step();
      k_force = 0;
      d_pend = 1; dwen = 0; da = 64'h2000; drive_ports();
      repeat (6) step();
      chk("t4_done", 64'(sb.size() + fq.size()), 64'd0);

      // Reset in WAIT after a streak-counting D grant, then a late response.
      k_force = 99;
      i_pend = 1; d_pend = 1; dwen = 0; da = 64'h3000; ia = 64'h4000; drive_ports();
      repeat (5) step();
      rst = 1'b1; i_pend = 0; d_pend = 0; drive_ports();
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_model();
      k_force = 0;
      mem_rvalid = 1'b1; mem_rdata = 64'hbad;
      @(negedge clk);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_mem_req", 64'(mem_req_valid), 64'd0);
      @(posedge clk);
      #1;
      repeat (4) step();
      glog = ""; log_on = 1; i_rate = 100; d_rate = 100;
      run_until_grants(5, 100);
      log_on = 0;
      chks("grant_order_after_rst", glog, "DDDDI");
      drain(200);

      // Memory stalls REQ for five cycles while requesters present new fields.
      rdy_rate = 0; d_rate = 100; i_rate = 100;
      d_pend = 1; dwen = 1; da = 64'h5000; dwd = 64'hcafe; dwl = 2'd3; drive_ports();
      repeat (6) step();
      drain(200);

      // Randomised traffic with random memory latency including timeouts.
      k_force = -1; i_rate = 35; d_rate = 35; rdy_rate = 60;
      repeat (800) step();
      drain(300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
